// File: rtl/mrhy4_stream_decoder_if.sv
// Handshake bundle between an mrHY4 digit-serial sender and the parallel-word decoder.
// The master drives digits and out_ready; the slave (decoder) returns in_ready and the decoded word.
interface mrhy4_stream_decoder_if #(
  parameter int OUT_W = 9
);
  logic             in_valid;
  logic             in_first;
  logic             n2;
  logic             p;
  logic             pp;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;
  logic             out_ovf;
  logic             frame_err;

  modport master (
    output in_valid, in_first, n2, p, pp, out_ready,
    input  in_ready, out_valid, out_word, out_ovf, frame_err
  );

  modport slave (
    input  in_valid, in_first, n2, p, pp, out_ready,
    output in_ready, out_valid, out_word, out_ovf, frame_err
  );
endinterface

// File: rtl/mrhy4_stream_decoder.sv
// Reassembles LSD-first redundant radix-4 mrHY4 digit frames into saturated two's-complement words.
// Only the digit that would complete a frame stalls, and only while the previous word is still unread.
module mrhy4_stream_decoder #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 2*DIGITS+1
) (
  input logic                   clk,
  input logic                   rst,
  mrhy4_stream_decoder_if.slave bus
);
  localparam int AW = 2*DIGITS+2;
  localparam int CW = $clog2(DIGITS);
  localparam int SW = AW + OUT_W;
  localparam logic [CW-1:0] LAST = CW'(DIGITS-1);
  localparam logic signed [SW-1:0] MAX_POS = (SW'(1) << (OUT_W-1)) - SW'(1);
  localparam logic signed [SW-1:0] MAX_NEG = -(SW'(1) << (OUT_W-1));

  typedef enum logic {IDLE, ACC} StateT;

  StateT                   r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [AW-1:0]    r_acc;
  logic [OUT_W-1:0]        r_outWord;
  logic                    r_outOvf;
  logic                    r_outValid;
  logic                    r_frameErr;

  logic signed [2:0]       w_digit;
  logic signed [AW-1:0]    w_digitExt;
  logic signed [AW-1:0]    w_digitShifted;
  logic signed [AW-1:0]    w_sum;
  logic signed [SW-1:0]    w_sumExt;
  logic                    w_posSat;
  logic                    w_negSat;
  logic [OUT_W-1:0]        w_satWord;
  logic                    w_lastPos;
  logic                    w_inReady;
  logic                    w_xfer;

  // Digit value pp + p - 2*n2 always fits in 3 signed bits (-2..+2).
  assign w_digit        = 3'(bus.pp) + 3'(bus.p) - {1'b0, bus.n2, 1'b0};
  assign w_digitExt     = {{(AW-3){w_digit[2]}}, w_digit};
  assign w_digitShifted = w_digitExt << {r_cnt, 1'b0};
  assign w_sum          = r_acc + w_digitShifted;
  assign w_sumExt       = {{OUT_W{w_sum[AW-1]}}, w_sum};

  assign w_posSat  = w_sumExt > MAX_POS;
  assign w_negSat  = w_sumExt < MAX_NEG;
  assign w_satWord = w_posSat ? {1'b0, {(OUT_W-1){1'b1}}} :
                     w_negSat ? {1'b1, {(OUT_W-1){1'b0}}} :
                                w_sumExt[OUT_W-1:0];

  assign w_lastPos = (r_state == ACC) && (r_cnt == LAST);
  assign w_inReady = ~(w_lastPos & r_outValid & ~bus.out_ready);
  assign w_xfer    = bus.in_valid & w_inReady;

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_word  = r_outWord;
  assign bus.out_ovf   = r_outOvf;
  assign bus.frame_err = r_frameErr;

  // A completing digit loads the output register; that load overrides the consumer clearing out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_outWord  <= '0;
      r_outOvf   <= 1'b0;
      r_outValid <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;
      if (r_outValid && bus.out_ready) begin
        r_outValid <= 1'b0;
      end
      if (w_xfer) begin
        if (bus.in_first) begin
          r_frameErr <= (r_state == ACC);
          r_acc      <= w_digitExt;
          r_cnt      <= CW'(1);
          r_state    <= ACC;
        end else if (r_state == IDLE) begin
          r_frameErr <= 1'b1;
        end else if (r_cnt == LAST) begin
          r_outWord  <= w_satWord;
          r_outOvf   <= w_posSat | w_negSat;
          r_outValid <= 1'b1;
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_acc      <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mrhy4_stream_decoder.sv
// Drives two decoders (9-bit exact and 8-bit saturating) with identical digit streams and
// compares both against a frame-level arithmetic model.
module tb_mrhy4_stream_decoder;
  localparam int DIGITS = 4;

  logic clk;
  logic rst;
  logic inValid;
  logic inFirst;
  logic [2:0] code;
  logic outReady;

  int checkCount = 0;
  int passCount  = 0;

  int  frameDigits[$];
  bit  expValid;
  int  expWord9;
  int  expWord8;
  bit  expOvf9;
  bit  expOvf8;

  mrhy4_stream_decoder_if #(.OUT_W(9)) bus9 ();
  mrhy4_stream_decoder_if #(.OUT_W(8)) bus8 ();

  assign bus9.in_valid  = inValid;
  assign bus9.in_first  = inFirst;
  assign bus9.n2        = code[2];
  assign bus9.p         = code[1];
  assign bus9.pp        = code[0];
  assign bus9.out_ready = outReady;
  assign bus8.in_valid  = inValid;
  assign bus8.in_first  = inFirst;
  assign bus8.n2        = code[2];
  assign bus8.p         = code[1];
  assign bus8.pp        = code[0];
  assign bus8.out_ready = outReady;

  mrhy4_stream_decoder #(.DIGITS(DIGITS), .OUT_W(9)) dut9 (
    .clk (clk),
    .rst (rst),
    .bus (bus9)
  );

  mrhy4_stream_decoder #(.DIGITS(DIGITS), .OUT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  function automatic int digitVal(input logic [2:0] c);
    return int'(c[0]) + int'(c[1]) - 2 * int'(c[2]);
  endfunction

  function automatic int satWord(input int v, input int w, output bit ovf);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    ovf = 1'b0;
    if (v > hi) begin ovf = 1'b1; return hi; end
    if (v < lo) begin ovf = 1'b1; return lo; end
    return v;
  endfunction

  task automatic checkHeld();
    checkOutput("out_valid9", int'(bus9.out_valid), int'(expValid));
    checkOutput("out_valid8", int'(bus8.out_valid), int'(expValid));
    if (expValid) begin
      checkOutput("out_word9", int'($signed(bus9.out_word)), expWord9);
      checkOutput("out_word8", int'($signed(bus8.out_word)), expWord8);
      checkOutput("out_ovf9", int'(bus9.out_ovf), int'(expOvf9));
      checkOutput("out_ovf8", int'(bus8.out_ovf), int'(expOvf8));
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    inValid = 1'b0;
    inFirst = 1'b0;
    code = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frameDigits.delete();
    expValid = 1'b0;
    checkOutput("rst_out_valid", int'(bus9.out_valid) + int'(bus8.out_valid), 0);
    checkOutput("rst_out_word", int'(bus9.out_word) + int'(bus8.out_word), 0);
    checkOutput("rst_out_ovf", int'(bus9.out_ovf) + int'(bus8.out_ovf), 0);
    checkOutput("rst_frame_err", int'(bus9.frame_err) + int'(bus8.frame_err), 0);
    checkOutput("rst_in_ready", int'(bus9.in_ready) + int'(bus8.in_ready), 2);
  endtask

  // One clock: drive a digit (or a gap), check in_ready before the edge and all outputs after it.
  task automatic applyStimulus(input bit valid, input bit first, input logic [2:0] c);
    bit expReady, xfer, expErr, load;
    int v, weight;
    bit readyNow;
    inValid = valid;
    inFirst = first;
    code = c;
    #1;
    expReady = !(frameDigits.size() == DIGITS - 1 && expValid && !outReady);
    checkOutput("in_ready9", int'(bus9.in_ready), int'(expReady));
    checkOutput("in_ready8", int'(bus8.in_ready), int'(expReady));
    xfer = valid && expReady;
    readyNow = outReady;
    expErr = 1'b0;
    load = 1'b0;
    v = 0;
    if (xfer) begin
      if (first) begin
        expErr = (frameDigits.size() != 0);
        frameDigits.delete();
        frameDigits.push_back(digitVal(c));
      end else if (frameDigits.size() == 0) begin
        expErr = 1'b1;
      end else begin
        frameDigits.push_back(digitVal(c));
        if (frameDigits.size() == DIGITS) begin
          weight = 1;
          foreach (frameDigits[k]) begin
            v += frameDigits[k] * weight;
            weight *= 4;
          end
          load = 1'b1;
          frameDigits.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    if (expValid && readyNow) expValid = 1'b0;
    if (load) begin
      expValid = 1'b1;
      expWord9 = satWord(v, 9, expOvf9);
      expWord8 = satWord(v, 8, expOvf8);
    end
    inValid = 1'b0;
    checkOutput("frame_err9", int'(bus9.frame_err), int'(expErr));
    checkOutput("frame_err8", int'(bus8.frame_err), int'(expErr));
    checkHeld();
  endtask

  task automatic sendFrame(input logic [2:0] c0, input logic [2:0] c1,
                           input logic [2:0] c2, input logic [2:0] c3);
    applyStimulus(1'b1, 1'b1, c0);
    applyStimulus(1'b1, 1'b0, c1);
    applyStimulus(1'b1, 1'b0, c2);
    applyStimulus(1'b1, 1'b0, c3);
  endtask

  initial begin
    bit first;
    rst = 1'b1;
    outReady = 1'b1;
    expValid = 1'b0;
    expWord9 = 0;
    expWord8 = 0;
    expOvf9 = 1'b0;
    expOvf8 = 1'b0;
    doReset();

    sendFrame(3'b000, 3'b000, 3'b000, 3'b000);
    checkOutput("zero_word", int'($signed(bus9.out_word)), 0);
    sendFrame(3'b011, 3'b011, 3'b011, 3'b011);
    checkOutput("plus2_word9", int'($signed(bus9.out_word)), 170);
    checkOutput("plus2_word8", int'($signed(bus8.out_word)), 127);
    sendFrame(3'b100, 3'b100, 3'b100, 3'b100);
    checkOutput("minus2_word9", int'($signed(bus9.out_word)), -170);
    checkOutput("minus2_word8", int'($signed(bus8.out_word)), -128);
    sendFrame(3'b001, 3'b110, 3'b111, 3'b010);
    checkOutput("mixed_word", int'($signed(bus9.out_word)), 61);
    sendFrame(3'b001, 3'b101, 3'b111, 3'b010);
    checkOutput("alt_code_word", int'($signed(bus9.out_word)), 61);
    applyStimulus(1'b0, 1'b0, 3'b000);

    // Backpressure: the completing digit of the second frame must wait for the consumer.
    outReady = 1'b0;
    sendFrame(3'b011, 3'b011, 3'b011, 3'b011);
    applyStimulus(1'b1, 1'b1, 3'b001);
    applyStimulus(1'b1, 1'b0, 3'b110);
    applyStimulus(1'b1, 1'b0, 3'b111);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'b010);
    checkOutput("held_word", int'($signed(bus9.out_word)), 170);
    outReady = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010);
    checkOutput("second_word", int'($signed(bus9.out_word)), 61);
    applyStimulus(1'b0, 1'b0, 3'b000);

    // Restart mid-frame, stray digit in IDLE, and reset mid-frame.
    applyStimulus(1'b1, 1'b1, 3'b011);
    applyStimulus(1'b1, 1'b0, 3'b011);
    sendFrame(3'b001, 3'b000, 3'b000, 3'b001);
    checkOutput("restart_word", int'($signed(bus9.out_word)), 65);
    applyStimulus(1'b1, 1'b0, 3'b011);
    applyStimulus(1'b1, 1'b1, 3'b001);
    applyStimulus(1'b1, 1'b0, 3'b001);
    doReset();
    sendFrame(3'b100, 3'b000, 3'b000, 3'b011);
    checkOutput("post_rst_word", int'($signed(bus9.out_word)), 126);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        doReset();
      end else begin
        if (frameDigits.size() == 0) first = ($urandom_range(0, 9) != 0);
        else first = ($urandom_range(0, 19) == 0);
        outReady = ($urandom_range(0, 3) != 0);
        applyStimulus($urandom_range(0, 4) != 0, first, 3'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
